dmc_fill_ctrl: RTL and testbench
================================

DMC_FILL_CTRL -- requirements
Module: dmc_fill_ctrl

Interface
REQ-001 SHALL have parameter LINE_SIZE, default 16, meaning cache line bytes (power of 2, >=4); LW = LINE_SIZE*8, OW = log2(LINE_SIZE).
REQ-002 SHALL have port clk  in  1  sole clock, all state on rising edge.
REQ-003 SHALL have port rst_n  in  1  reset, synchronous, active-low.
REQ-004 SHALL have port req_valid  in  1  requester read request.
REQ-005 SHALL have port req_addr  in  24  requester byte address.
REQ-006 SHALL have port req_done  out  1  one-cycle pulse, rdata valid.
REQ-007 SHALL have port rdata  out  32  returned word.
REQ-008 SHALL have port cache_A  out  24  lookup/fill address to cache.
REQ-009 SHALL have port cache_hit  in  1  cache hit for cache_A.
REQ-010 SHALL have port cache_Do  in  32  cache word for cache_A.
REQ-011 SHALL have port cache_line  out  LW  fill data to cache.
REQ-012 SHALL have port cache_wr  out  1  cache line write strobe.
REQ-013 SHALL have port fr_rd  out  1  flash line-read request (level).
REQ-014 SHALL have port fr_addr  out  24  line-aligned flash address.
REQ-015 SHALL have port fr_done  in  1  flash line-read complete, fr_line valid this cycle.
REQ-016 SHALL have port fr_line  in  LW  flash line data.
REQ-017 SHALL have port clr_stats  in  1  clear statistics counters.
REQ-018 SHALL have ports hit_cnt, miss_cnt  out  16 each  statistics counters.

Function
REQ-019 SHALL implement FSM states IDLE, LOOKUP, FILL, RESP.
REQ-020 IDLE: when req_valid=1 SHALL latch req_addr into addr_q and go to LOOKUP; otherwise stay.
REQ-021 cache_A SHALL equal addr_q in all states; req_addr changes after acceptance SHALL be ignored.
REQ-022 LOOKUP, cache_hit=1: SHALL register rdata<=cache_Do and go to RESP.
REQ-023 LOOKUP, cache_hit=0: SHALL go to FILL; fr_rd SHALL be 1 from the next cycle.
REQ-024 fr_addr SHALL be {addr_q[23:OW], OW zeros}, stable while fr_rd=1.
REQ-025 FILL: fr_rd SHALL stay 1 until a cycle with fr_done=1; fr_rd SHALL be 0 in the cycle after fr_done.
REQ-026 cache_line SHALL equal fr_line combinationally; cache_wr SHALL be (state==FILL)&fr_done.
REQ-027 FILL with fr_done=1 SHALL go to LOOKUP (re-lookup, which hits).
REQ-028 RESP: req_done SHALL be 1 for exactly one cycle, then go to IDLE; rdata SHALL hold until the next LOOKUP hit.
REQ-029 Hit latency SHALL be: accept edge N, req_done high in cycle N+2.
REQ-030 Miss latency SHALL be: req_done two cycles after the fr_done cycle.
REQ-031 fr_done outside FILL SHALL be ignored (no cache_wr, no state change).
REQ-032 A new request SHALL be accepted in IDLE the cycle after RESP; back-to-back requests SHALL give req_done at most every 3 cycles.
REQ-033 hit_cnt SHALL increment on a LOOKUP hit that is not the re-lookup following a fill.
REQ-034 miss_cnt SHALL increment on each LOOKUP miss.
REQ-035 Both counters SHALL saturate at 0xFFFF.
REQ-036 clr_stats=1 SHALL zero both counters next edge; clear SHALL win over a simultaneous increment.

Reset
REQ-037 rst_n=0 at a rising edge SHALL force state IDLE and zero addr_q, rdata, hit_cnt and miss_cnt, with outputs req_done=0, fr_rd=0, cache_wr=0 from that edge.
REQ-038 Reset during FILL SHALL drop fr_rd next edge and abandon the request with no req_done.
REQ-039 Cache VALID clearing SHALL remain the cache's responsibility.

Verification
REQ-040 Hit: cache preloaded, req 0x000124 -> req_done in cycle N+2, rdata=cache word, hit_cnt=1, fr_rd never 1.
REQ-041 Miss: req 0x012348, LINE_SIZE=16 -> fr_addr=0x012340, fr_rd held for 5 cycles until fr_done; cache_wr pulses once; req_done 2 cycles later; rdata=fr_line[95:64]; miss_cnt=1, hit_cnt=0.
REQ-042 Stray fr_done in IDLE/RESP -> no cache_wr, no state change.
REQ-043 Reset asserted 2 cycles into FILL -> fr_rd=0 next edge, no req_done, counters 0.
REQ-044 Saturation: 65537 hits -> hit_cnt=0xFFFF; clr_stats together with a hit -> hit_cnt=0.
REQ-045 Back-to-back hits with req_valid held -> req_done every 3 cycles; req_addr changed mid-lookup -> rdata from the latched address.

Source files
------------

// File: rtl/dmc_fill_ctrl.sv
// Cache fill controller: looks up a requested word in the cache and, on a miss,
// fetches the whole line from flash, writes it to the cache and re-looks it up.
module dmc_fill_ctrl #(
  parameter int LINE_SIZE = 16,
  localparam int LW = LINE_SIZE * 8,
  localparam int OW = $clog2(LINE_SIZE)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  input  logic [23:0]   req_addr,
  output logic          req_done,
  output logic [31:0]   rdata,
  output logic [23:0]   cache_A,
  input  logic          cache_hit,
  input  logic [31:0]   cache_Do,
  output logic [LW-1:0] cache_line,
  output logic          cache_wr,
  output logic          fr_rd,
  output logic [23:0]   fr_addr,
  input  logic          fr_done,
  input  logic [LW-1:0] fr_line,
  input  logic          clr_stats,
  output logic [15:0]   hit_cnt,
  output logic [15:0]   miss_cnt
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] LOOKUP = 2'd1;
  localparam logic [1:0] FILL   = 2'd2;
  localparam logic [1:0] RESP   = 2'd3;

  logic [1:0]  state;
  logic [23:0] addr_q;
  logic        refill_q;
  logic        lookup_hit;
  logic        lookup_miss;

  assign cache_A     = addr_q;
  assign fr_addr     = {addr_q[23:OW], {OW{1'b0}}};
  assign fr_rd       = (state == FILL);
  assign req_done    = (state == RESP);
  assign cache_line  = fr_line;
  assign cache_wr    = (state == FILL) && fr_done;
  assign lookup_hit  = (state == LOOKUP) && cache_hit;
  assign lookup_miss = (state == LOOKUP) && !cache_hit;

  // refill_q marks the re-lookup after a fill so it is not counted as a hit
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      addr_q   <= '0;
      rdata    <= '0;
      refill_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            addr_q <= req_addr;
            state  <= LOOKUP;
          end
        end
        LOOKUP: begin
          refill_q <= 1'b0;
          if (cache_hit) begin
            rdata <= cache_Do;
            state <= RESP;
          end else begin
            state <= FILL;
          end
        end
        FILL: begin
          if (fr_done) begin
            refill_q <= 1'b1;
            state    <= LOOKUP;
          end
        end
        RESP: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Saturating statistics; a clear overrides any increment in the same cycle
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else if (clr_stats) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else begin
      if (lookup_hit && !refill_q && hit_cnt != 16'hFFFF)
        hit_cnt <= hit_cnt + 16'd1;
      if (lookup_miss && miss_cnt != 16'hFFFF)
        miss_cnt <= miss_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_dmc_fill_ctrl.sv
// Directed bench for dmc_fill_ctrl with a small behavioural cache model that
// answers lookups and absorbs line writes.
module tb_dmc_fill_ctrl;

  localparam int LINE_SIZE = 16;
  localparam int LW = LINE_SIZE * 8;

  localparam logic [127:0] L12 = {32'hA3A3A3A3, 32'hA2A2A2A2, 32'hA1A1A1A1, 32'hA0A0A0A0};
  localparam logic [127:0] L13 = {32'hB3B3B3B3, 32'hB2B2B2B2, 32'hB1B1B1B1, 32'hB0B0B0B0};
  localparam logic [127:0] LF  = {32'hC3C3C3C3, 32'hC2C2C2C2, 32'hC1C1C1C1, 32'hC0C0C0C0};

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_valid;
  logic [23:0]   req_addr;
  logic          req_done;
  logic [31:0]   rdata;
  logic [23:0]   cache_A;
  logic          cache_hit;
  logic [31:0]   cache_Do;
  logic [LW-1:0] cache_line;
  logic          cache_wr;
  logic          fr_rd;
  logic [23:0]   fr_addr;
  logic          fr_done;
  logic [LW-1:0] fr_line;
  logic          clr_stats;
  logic [15:0]   hit_cnt;
  logic [15:0]   miss_cnt;

  int tests = 0;
  int fails = 0;
  int wr_count = 0;
  int cache_upd = 0;
  logic fr_rd_seen = 1'b0;
  logic done_seen = 1'b0;
  logic [127:0] cache_mem [bit [19:0]];

  dmc_fill_ctrl #(.LINE_SIZE(LINE_SIZE)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_addr(req_addr),
    .req_done(req_done), .rdata(rdata), .cache_A(cache_A), .cache_hit(cache_hit),
    .cache_Do(cache_Do), .cache_line(cache_line), .cache_wr(cache_wr), .fr_rd(fr_rd),
    .fr_addr(fr_addr), .fr_done(fr_done), .fr_line(fr_line), .clr_stats(clr_stats),
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  always #5 clk = ~clk;

  // Cache model: hit when the line is present, word picked by address bits [3:2]
  always @(cache_A or cache_upd) begin
    logic [127:0] line;
    cache_hit = cache_mem.exists(cache_A[23:4]);
    cache_Do  = 32'h0;
    if (cache_hit) begin
      line     = cache_mem[cache_A[23:4]];
      cache_Do = line[cache_A[3:2]*32 +: 32];
    end
  end

  always @(posedge clk) begin
    if (cache_wr) begin
      cache_mem[cache_A[23:4]] = cache_line;
      wr_count++;
      cache_upd++;
    end
    if (fr_rd) fr_rd_seen = 1'b1;
    if (req_done) done_seen = 1'b1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic [23:0] a);
    req_valid = v;
    req_addr  = a;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  task automatic doHit(input logic [23:0] a);
    applyStimulus(1'b1, a);
    tick();
    applyStimulus(1'b0, 24'h0);
    tick();
    tick();
  endtask

  initial begin
    rst_n = 1'b0;
    fr_done = 1'b0;
    fr_line = '0;
    clr_stats = 1'b0;
    applyStimulus(1'b0, 24'h0);
    cache_mem[20'h00012] = L12;
    cache_mem[20'h00013] = L13;
    cache_upd++;
    tick();
    tick();
    checkOutput("rst_req_done", {31'b0, req_done}, 32'h0);
    checkOutput("rst_fr_rd", {31'b0, fr_rd}, 32'h0);
    checkOutput("rst_cache_wr", {31'b0, cache_wr}, 32'h0);
    checkOutput("rst_hit_cnt", {16'b0, hit_cnt}, 32'h0);
    checkOutput("rst_miss_cnt", {16'b0, miss_cnt}, 32'h0);
    checkOutput("rst_rdata", rdata, 32'h0);
    checkOutput("rst_cache_A", {8'b0, cache_A}, 32'h0);
    rst_n = 1'b1;
    tick();

    // Hit on a preloaded line
    fr_rd_seen = 1'b0;
    applyStimulus(1'b1, 24'h000124);
    tick();
    checkOutput("hit_cache_A", {8'b0, cache_A}, 32'h000124);
    checkOutput("hit_done_early", {31'b0, req_done}, 32'h0);
    applyStimulus(1'b0, 24'hFFFFFF);
    tick();
    checkOutput("hit_done", {31'b0, req_done}, 32'h1);
    checkOutput("hit_rdata", rdata, 32'hA1A1A1A1);
    checkOutput("hit_cnt_1", {16'b0, hit_cnt}, 32'h1);
    tick();
    checkOutput("hit_done_pulse", {31'b0, req_done}, 32'h0);
    checkOutput("hit_rdata_hold", rdata, 32'hA1A1A1A1);
    checkOutput("hit_no_fr_rd", {31'b0, fr_rd_seen}, 32'h0);

    clr_stats = 1'b1;
    tick();
    clr_stats = 1'b0;
    checkOutput("clr_hit_cnt", {16'b0, hit_cnt}, 32'h0);

    // Miss: five-cycle flash read, fill, re-lookup
    wr_count = 0;
    applyStimulus(1'b1, 24'h012348);
    tick();
    applyStimulus(1'b0, 24'h0);
    checkOutput("miss_lookup_fr_rd", {31'b0, fr_rd}, 32'h0);
    tick();
    checkOutput("miss_fr_rd_1", {31'b0, fr_rd}, 32'h1);
    checkOutput("miss_fr_addr", {8'b0, fr_addr}, 32'h012340);
    checkOutput("miss_cnt_1", {16'b0, miss_cnt}, 32'h1);
    for (int i = 2; i <= 4; i++) begin
      tick();
      checkOutput("miss_fr_rd_hold", {31'b0, fr_rd}, 32'h1);
      checkOutput("miss_fr_addr_hold", {8'b0, fr_addr}, 32'h012340);
    end
    tick();
    fr_line = LF;
    fr_done = 1'b1;
    #1;
    checkOutput("miss_cache_wr", {31'b0, cache_wr}, 32'h1);
    checkOutput("miss_cache_line", cache_line[95:64], 32'hC2C2C2C2);
    tick();
    fr_done = 1'b0;
    fr_line = '0;
    checkOutput("miss_fr_rd_drop", {31'b0, fr_rd}, 32'h0);
    checkOutput("miss_wr_drop", {31'b0, cache_wr}, 32'h0);
    checkOutput("miss_done_early", {31'b0, req_done}, 32'h0);
    tick();
    checkOutput("miss_done", {31'b0, req_done}, 32'h1);
    checkOutput("miss_rdata", rdata, 32'hC2C2C2C2);
    checkOutput("miss_cnt_final", {16'b0, miss_cnt}, 32'h1);
    checkOutput("miss_hit_cnt", {16'b0, hit_cnt}, 32'h0);
    checkOutput("miss_wr_count", wr_count, 32'h1);
    tick();
    checkOutput("miss_done_pulse", {31'b0, req_done}, 32'h0);

    // Stray fr_done in IDLE and in RESP
    fr_done = 1'b1;
    #1;
    checkOutput("stray_idle_wr", {31'b0, cache_wr}, 32'h0);
    tick();
    fr_done = 1'b0;
    checkOutput("stray_idle_fr_rd", {31'b0, fr_rd}, 32'h0);
    checkOutput("stray_idle_done", {31'b0, req_done}, 32'h0);
    applyStimulus(1'b1, 24'h000124);
    tick();
    applyStimulus(1'b0, 24'h0);
    tick();
    fr_done = 1'b1;
    #1;
    checkOutput("stray_resp_done", {31'b0, req_done}, 32'h1);
    checkOutput("stray_resp_wr", {31'b0, cache_wr}, 32'h0);
    tick();
    fr_done = 1'b0;
    checkOutput("stray_resp_next_done", {31'b0, req_done}, 32'h0);
    checkOutput("stray_resp_fr_rd", {31'b0, fr_rd}, 32'h0);
    tick();
    checkOutput("stray_resp_idle", {31'b0, req_done | fr_rd}, 32'h0);
    checkOutput("stray_wr_count", wr_count, 32'h1);
    checkOutput("stray_hit_cnt", {16'b0, hit_cnt}, 32'h1);

    // Reset two cycles into FILL
    applyStimulus(1'b1, 24'h0200F0);
    tick();
    applyStimulus(1'b0, 24'h0);
    tick();
    tick();
    checkOutput("rstfill_fr_rd_before", {31'b0, fr_rd}, 32'h1);
    rst_n = 1'b0;
    tick();
    checkOutput("rstfill_fr_rd", {31'b0, fr_rd}, 32'h0);
    checkOutput("rstfill_done", {31'b0, req_done}, 32'h0);
    checkOutput("rstfill_cnts", {hit_cnt, miss_cnt}, 32'h0);
    rst_n = 1'b1;
    done_seen = 1'b0;
    fr_rd_seen = 1'b0;
    repeat (4) tick();
    checkOutput("rstfill_no_done", {31'b0, done_seen}, 32'h0);
    checkOutput("rstfill_no_fr_rd", {31'b0, fr_rd_seen}, 32'h0);

    // Saturation near the top of the hit counter, then clear beats a hit
    force dut.hit_cnt = 16'hFFFE;
    tick();
    release dut.hit_cnt;
    doHit(24'h000124);
    checkOutput("sat_hit_ffff", {16'b0, hit_cnt}, 32'hFFFF);
    doHit(24'h000124);
    checkOutput("sat_hit_hold", {16'b0, hit_cnt}, 32'hFFFF);
    applyStimulus(1'b1, 24'h000124);
    tick();
    applyStimulus(1'b0, 24'h0);
    clr_stats = 1'b1;
    tick();
    clr_stats = 1'b0;
    checkOutput("sat_clr_wins", {16'b0, hit_cnt}, 32'h0);
    tick();

    // Back-to-back hits with req_valid held; address changed mid-lookup
    applyStimulus(1'b1, 24'h000124);
    tick();
    req_addr = 24'h000138;
    tick();
    checkOutput("b2b_done_1", {31'b0, req_done}, 32'h1);
    checkOutput("b2b_rdata_1", rdata, 32'hA1A1A1A1);
    tick();
    checkOutput("b2b_idle", {31'b0, req_done}, 32'h0);
    tick();
    checkOutput("b2b_lookup", {31'b0, req_done}, 32'h0);
    checkOutput("b2b_cache_A", {8'b0, cache_A}, 32'h000138);
    tick();
    applyStimulus(1'b0, 24'h0);
    checkOutput("b2b_done_2", {31'b0, req_done}, 32'h1);
    checkOutput("b2b_rdata_2", rdata, 32'hB2B2B2B2);
    tick();
    checkOutput("b2b_done_end", {31'b0, req_done}, 32'h0);
    checkOutput("b2b_hit_cnt", {16'b0, hit_cnt}, 32'h2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
